dft2_stream: RTL and testbench

DFT2_STREAM -- requirements
Module: dft2_stream

---
 rtl/dft_pkg.sv | 17 +
 rtl/dft2_sat.sv | 17 +
 rtl/dft2_stream.sv | 85 ++++++++
 tb/tb_dft2_stream.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// dft_pkg: Q-format defaults and complex pack/unpack helpers shared by the DFT blocks
package dft_pkg;
  localparam int DFT_WIDTH = 16;
  localparam int DFT_FRAC = 7;
  localparam logic [DFT_WIDTH-1:0] DFT_ONE = DFT_WIDTH'(1 << DFT_FRAC);
  typedef logic [DFT_WIDTH-1:0] comp_t;
  typedef logic [2*DFT_WIDTH-1:0] cplx_t;
  function automatic cplx_t cpack(comp_t re, comp_t im);
    return {im, re};
  endfunction
  function automatic comp_t cre(cplx_t c);
    return c[DFT_WIDTH-1:0];
  endfunction
  function automatic comp_t cim(cplx_t c);
    return c[2*DFT_WIDTH-1:DFT_WIDTH];
  endfunction
endpackage

// File: rtl/dft2_sat.sv
// dft2_sat: narrows a WIDTH+1-bit butterfly term by halving or saturating, flagging overflow
module dft2_sat #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   x,
  input  logic             scale,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic sat;
  // halving always fits; otherwise clamp when the two top bits disagree
  always_comb begin
    sat = x[WIDTH] ^ x[WIDTH-1];
    ovf = !scale && sat;
    y = scale ? x[WIDTH:1] : sat ? {x[WIDTH], {(WIDTH-1){~x[WIDTH]}}} : x[WIDTH-1:0];
  end
endmodule

// File: rtl/dft2_stream.sv
// dft2_stream: streaming radix-2 butterfly (a+b, a-b) with a two-stage valid/ready pipeline
module dft2_stream
  import dft_pkg::*;
#(
  parameter int WIDTH = DFT_WIDTH,
  parameter int FRAC = DFT_FRAC,
  parameter int PAIRS = 16
) (
  input  logic                     clk_100,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH-1:0]       in_a,
  input  logic [2*WIDTH-1:0]       in_b,
  input  logic                     scale_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out0,
  output logic [2*WIDTH-1:0]       out1,
  output logic                     out_last,
  output logic [$clog2(PAIRS)-1:0] frame_cnt,
  input  logic                     clr_ovf,
  output logic                     ovf
);
  localparam int CW = $clog2(PAIRS);
  if (PAIRS < 2 || (PAIRS & (PAIRS - 1)) != 0 || FRAC >= WIDTH) begin : g_bad_cfg
    $error("dft2_stream: unsupported WIDTH/FRAC/PAIRS");
  end
  logic s1_valid, s1_scale, s2_valid, s2_take, s1_adv;
  logic [3:0][WIDTH:0] s1_sum;
  logic [3:0][WIDTH-1:0] sat_y;
  logic [3:0] sat_ovf;
  logic [WIDTH:0] ar, ai, br, bi;
  assign ar = {in_a[WIDTH-1], in_a[WIDTH-1:0]};
  assign ai = {in_a[2*WIDTH-1], in_a[2*WIDTH-1:WIDTH]};
  assign br = {in_b[WIDTH-1], in_b[WIDTH-1:0]};
  assign bi = {in_b[2*WIDTH-1], in_b[2*WIDTH-1:WIDTH]};
  assign s2_take = !s2_valid || out_ready;
  assign s1_adv = s1_valid && s2_take;
  assign in_ready = reset && (!s1_valid || s2_take);
  assign out_valid = s2_valid;
  assign out_last = s2_valid && frame_cnt == CW'(PAIRS - 1);
  for (genvar i = 0; i < 4; i++) begin : g_sat
    dft2_sat #(.WIDTH(WIDTH)) u_sat (.x(s1_sum[i]), .scale(s1_scale), .y(sat_y[i]), .ovf(sat_ovf[i]));
  end
  // S1: full-precision sums/differences, order {im diff, re diff, im sum, re sum}
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_sum <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_scale <= scale_en;
        s1_sum <= {ai - bi, ar - br, ai + bi, ar + br};
      end
    end
  end
  // S2: narrowed results held until the downstream takes them
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      out0 <= '0;
      out1 <= '0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out0 <= {sat_y[1], sat_y[0]};
        out1 <= {sat_y[3], sat_y[2]};
      end
    end
  end
  // sticky overflow (a new set beats a clear) and output index within the frame
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      ovf <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (s1_adv && |sat_ovf) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (s2_valid && out_ready) frame_cnt <= frame_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_dft2_stream.sv
// tb_dft2_stream: directed self-checking bench for dft2_stream
module tb_dft2_stream;
  import dft_pkg::*;
  logic clk_100 = 1'b0, reset = 1'b0, in_valid = 1'b0, scale_en = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_last, ovf;
  logic [31:0] out0, out1;
  logic [3:0] frame_cnt;
  int errors = 0, checks = 0;

  dft2_stream dut (
    .clk_100(clk_100), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .scale_en(scale_en), .out_valid(out_valid),
    .out_ready(out_ready), .out0(out0), .out1(out1), .out_last(out_last),
    .frame_cnt(frame_cnt), .clr_ovf(clr_ovf), .ovf(ovf)
  );

  always #5 clk_100 = ~clk_100;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] fix(int v, logic sc);
    if (sc) return 16'(v >>> 1);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic sc);
    int ar, ai, br, bi;
    ar = int'($signed(a[15:0]));
    ai = int'($signed(a[31:16]));
    br = int'($signed(b[15:0]));
    bi = int'($signed(b[31:16]));
    return {fix(ai - bi, sc), fix(ar - br, sc), fix(ai + bi, sc), fix(ar + br, sc)};
  endfunction

  task automatic tick;
    @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0; scale_en = 1'b0; in_a = '0; in_b = '0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_a = 32'h1234_5678; in_b = 32'h0101_0101;
    tick;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out0 !== 32'h0 || out1 !== 32'h0) begin errors++; $display("FAIL reset_outs got %h/%h want 0/0", out0, out1); end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    do_reset;
    in_a = cpack(DFT_ONE, 16'h0); in_b = cpack(DFT_ONE, 16'h0); in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", out_valid); end
    checks++; if (out0 !== 32'h0000_0100) begin errors++; $display("FAIL basic_out0 got %h want 00000100", out0); end
    checks++; if (out1 !== 32'h0000_0000) begin errors++; $display("FAIL basic_out1 got %h want 00000000", out1); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_scale;
    do_reset;
    scale_en = 1'b1; in_valid = 1'b1; in_a = 32'h0000_0080; in_b = 32'h0000_0080;
    tick;
    in_a = 32'h0000_0001; in_b = 32'h0000_0000;
    tick;
    checks++; if (out0 !== 32'h0000_0080 || out1 !== 32'h0) begin errors++; $display("FAIL scale_half got %h/%h want 00000080/00000000", out0, out1); end
    in_a = 32'h0000_FFFF; in_b = 32'h0000_0000;
    tick;
    in_valid = 1'b0;
    checks++; if (out0 !== 32'h0 || out1 !== 32'h0) begin errors++; $display("FAIL scale_trunc got %h/%h want 00000000/00000000", out0, out1); end
    tick;
    checks++; if (out0 !== 32'h0000_FFFF || out1 !== 32'h0000_FFFF) begin errors++; $display("FAIL scale_neg got %h/%h want 0000ffff/0000ffff", out0, out1); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL scale_no_ovf got %b want 0", ovf); end
  endtask

  task automatic test_saturation;
    do_reset;
    in_a = 32'h0000_7FFF; in_b = 32'h0000_0001; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_early got %b want 0", ovf); end
    tick;
    checks++; if (out0 !== 32'h0000_7FFF || out1 !== 32'h0000_7FFE) begin errors++; $display("FAIL sat_pos got %h/%h want 00007fff/00007ffe", out0, out1); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set got %b want 1", ovf); end
    repeat (3) tick;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got %b want 1", ovf); end
    clr_ovf = 1'b1;
    tick;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear got %b want 0", ovf); end
    in_a = 32'h0000_8000; in_b = 32'h0000_0001; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_set_beats_clear got %b want 1", ovf); end
    checks++; if (out0 !== 32'h0000_8001 || out1 !== 32'h0000_8000) begin errors++; $display("FAIL sat_neg got %h/%h want 00008001/00008000", out0, out1); end
    clr_ovf = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [31:0] cur_a, cur_b, prev0, prev1;
    logic cur_sc, acc, hs, prev_stall, saw_full;
    int sent, recv;
    do_reset;
    sent = 0; recv = 0; prev_stall = 1'b0; saw_full = 1'b0; prev0 = '0; prev1 = '0;
    cur_a = $urandom; cur_b = $urandom; cur_sc = 1'($urandom_range(0, 1));
    for (int t = 0; t < 300 && recv < 20; t++) begin
      in_valid = (sent < 20) && ((t >= 6 && t <= 11) || $urandom_range(0, 2) != 0);
      out_ready = !(t >= 8 && t <= 10);
      in_a = cur_a; in_b = cur_b; scale_en = cur_sc;
      #1;
      acc = in_valid && in_ready;
      hs = out_valid && out_ready;
      if (t >= 8 && t <= 10 && in_ready === 1'b0) saw_full = 1'b1;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out0 !== prev0 || out1 !== prev1) begin errors++; $display("FAIL bp_hold got %b %h/%h want 1 %h/%h", out_valid, out0, out1, prev0, prev1); end
      end
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got %h/%h want nothing", out0, out1); end
        else begin
          exp_v = exp_q.pop_front();
          if ({out1, out0} !== exp_v) begin errors++; $display("FAIL bp_data#%0d got %h want %h", recv, {out1, out0}, exp_v); end
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back(model(cur_a, cur_b, cur_sc));
        sent++;
        cur_a = $urandom; cur_b = $urandom; cur_sc = 1'($urandom_range(0, 1));
      end
      prev_stall = out_valid && !out_ready;
      prev0 = out0; prev1 = out1;
      @(posedge clk_100);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv != 20) begin errors++; $display("FAIL bp_count got %0d want 20", recv); end
    checks++; if (!saw_full) begin errors++; $display("FAIL bp_in_ready got 1 want 0 while both stages full"); end
  endtask

  task automatic test_frame;
    int sent, k;
    do_reset;
    sent = 0; k = 0;
    for (int t = 0; t < 60 && k < 16; t++) begin
      in_valid = sent < 16; in_a = 32'(sent); in_b = '0;
      #1;
      if (out_valid && out_ready) begin
        checks++; if (frame_cnt !== 4'(k)) begin errors++; $display("FAIL frame_cnt got %0d want %0d", frame_cnt, k); end
        checks++; if (out_last !== (k == 15)) begin errors++; $display("FAIL frame_last#%0d got %b want %b", k, out_last, k == 15); end
        checks++; if (out0 !== 32'(k)) begin errors++; $display("FAIL frame_data#%0d got %h want %h", k, out0, 32'(k)); end
        k++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk_100);
      #1;
    end
    in_valid = 1'b0;
    checks++; if (k != 16) begin errors++; $display("FAIL frame_outputs got %0d want 16", k); end
    checks++; if (frame_cnt !== 4'd0 || out_last !== 1'b0) begin errors++; $display("FAIL frame_wrap got %0d/%b want 0/0", frame_cnt, out_last); end
  endtask

  task automatic test_reset_mid;
    int sent;
    logic found;
    do_reset;
    sent = 0; found = 1'b0;
    for (int t = 0; t < 40; t++) begin
      in_valid = 1'b1;
      in_a = sent == 0 ? 32'h0000_7FFF : 32'(sent);
      in_b = sent == 0 ? 32'h0000_0001 : 32'h0;
      #1;
      if (out_valid === 1'b1 && frame_cnt === 4'd5) begin found = 1'b1; break; end
      if (in_valid && in_ready) sent++;
      @(posedge clk_100);
      #1;
    end
    checks++; if (!found || ovf !== 1'b1) begin errors++; $display("FAIL mid_setup got found=%b ovf=%b want 1/1", found, ovf); end
    reset = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got %b%b%b want 000", out_valid, out_last, ovf); end
    checks++; if (frame_cnt !== 4'd0 || out0 !== 32'h0 || out1 !== 32'h0) begin errors++; $display("FAIL mid_reset_regs got %0d %h/%h want 0 0/0", frame_cnt, out0, out1); end
    reset = 1'b1; in_valid = 1'b1; in_a = 32'h0003_0002; in_b = 32'h0001_0001;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b1 || frame_cnt !== 4'd0) begin errors++; $display("FAIL mid_restart got %b/%0d want 1/0", out_valid, frame_cnt); end
    checks++; if (out0 !== 32'h0004_0003 || out1 !== 32'h0002_0001) begin errors++; $display("FAIL mid_restart_data got %h/%h want 00040003/00020001", out0, out1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_scale;
    test_saturation;
    test_backpressure;
    test_frame;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
